key_event_detector: RTL and testbench



---
 rtl/key_evt_pkg.sv | 18 +
 rtl/key_event_detector.sv | 117 +++++++++++
 tb/tb_key_event_detector.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event detector: FSM state encoding and
// default timing constants for a 50 MHz system clock.
package key_evt_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      WAIT2     = 3'd2,
      PRESS2    = 3'd3,
      LONG_HOLD = 3'd4
   } key_state_e;

   // 1 s hold for a long press, 300 ms max release gap for a double press
   localparam int unsigned DEF_LONG_CNT = 50_000_000;
   localparam int unsigned DEF_DBL_CNT  = 15_000_000;
   localparam int          DEF_CNT_W    = 32;

endpackage : key_evt_pkg

// File: rtl/key_event_detector.sv
// Classifies debounced key activity (active-low key) into single, double and
// long press events, each reported as a registered one-cycle pulse.
module key_event_detector
   import key_evt_pkg::*;
#(
   parameter int unsigned LONG_CNT = DEF_LONG_CNT,
   parameter int unsigned DBL_CNT  = DEF_DBL_CNT,
   parameter int          CNT_W    = DEF_CNT_W
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_flag,
   input  logic key_value,
   output logic single_press,
   output logic double_press,
   output logic long_press,
   output logic busy
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);

   key_state_e       r_state;
   logic [CNT_W-1:0] r_timer;
   logic             r_single;
   logic             r_double;
   logic             r_long;
   logic             r_busy;

   key_state_e       w_state_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic             w_single_nxt;
   logic             w_double_nxt;
   logic             w_long_nxt;
   logic             w_press_ev;
   logic             w_rel_ev;

   assign w_press_ev = key_flag & ~key_value;
   assign w_rel_ev   = key_flag &  key_value;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_single_nxt = 1'b0;
      w_double_nxt = 1'b0;
      w_long_nxt   = 1'b0;

      // Key events are tested before timeouts so an event arriving in the
      // timeout cycle takes precedence.
      case (r_state)
         IDLE: begin
            if (w_press_ev) w_state_nxt = PRESS1;
         end
         PRESS1: begin
            if (w_rel_ev) begin
               w_state_nxt = WAIT2;
            end else if (r_timer == LONG_LAST) begin
               w_state_nxt = LONG_HOLD;
               w_long_nxt  = 1'b1;
            end
         end
         WAIT2: begin
            if (w_press_ev) begin
               w_state_nxt = PRESS2;
            end else if (r_timer == DBL_LAST) begin
               w_state_nxt  = IDLE;
               w_single_nxt = 1'b1;
            end
         end
         PRESS2: begin
            if (w_rel_ev) begin
               w_state_nxt  = IDLE;
               w_double_nxt = 1'b1;
            end
         end
         LONG_HOLD: begin
            if (w_rel_ev) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_state_nxt != r_state) begin
         w_timer_nxt = '0;
      end else if (r_state == PRESS1 || r_state == WAIT2) begin
         w_timer_nxt = r_timer + CNT_W'(1);
      end else begin
         w_timer_nxt = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled at the same edge.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state  <= IDLE;
         r_timer  <= '0;
         r_single <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_single <= w_single_nxt;
         r_double <= w_double_nxt;
         r_long   <= w_long_nxt;
         r_busy   <= (w_state_nxt != IDLE);
      end
   end

   assign single_press = r_single;
   assign double_press = r_double;
   assign long_press   = r_long;
   assign busy         = r_busy;

endmodule : key_event_detector

// File: tb/tb_key_event_detector.sv
// Directed bench for key_event_detector with LONG_CNT=20, DBL_CNT=10; expected
// pulse edges are computed by hand from the edge that entered each state.
module tb_key_event_detector;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   logic key_flag;
   logic key_value;
   logic single_press;
   logic double_press;
   logic long_press;
   logic busy;

   int n_checks   = 0;
   int n_failures = 0;

   int cyc;
   int n_single, n_double, n_long, n_multi;
   int t_single, t_double, t_long;
   int t_ev;

   always #5 sys_clk = ~sys_clk;

   key_event_detector #(
      .LONG_CNT (20),
      .DBL_CNT  (10),
      .CNT_W    (32)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .key_flag     (key_flag),
      .key_value    (key_value),
      .single_press (single_press),
      .double_press (double_press),
      .long_press   (long_press),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock with the given inputs; outputs are sampled 1 ns after the edge.
   task automatic step(input logic flag, input logic val);
      key_flag  = flag;
      key_value = val;
      @(posedge sys_clk);
      #1;
      cyc++;
      key_flag = 1'b0;
      key_value = 1'b1;
      if (single_press === 1'b1) begin n_single++; t_single = cyc; end
      if (double_press === 1'b1) begin n_double++; t_double = cyc; end
      if (long_press   === 1'b1) begin n_long++;   t_long   = cyc; end
      if ((32'(single_press) + 32'(double_press) + 32'(long_press)) > 1) n_multi++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   task automatic press();
      step(1'b1, 1'b0);
   endtask

   task automatic release_key();
      step(1'b1, 1'b1);
   endtask

   task automatic clear_stats();
      n_single = 0; n_double = 0; n_long = 0;
      t_single = -1; t_double = -1; t_long = -1;
   endtask

   initial begin
      cyc = 0;
      n_multi = 0;
      key_flag = 1'b0;
      key_value = 1'b1;
      sys_rst_n = 1'b0;
      clear_stats();

      // Reset state
      idle(2);
      check("rst_busy", 32'(busy), 0);
      check("rst_pulses", 32'(single_press) + 32'(double_press) + 32'(long_press), 0);
      sys_rst_n = 1'b1;
      clear_stats();

      // 1) press at cycle 5, release at cycle 12 -> single 10 cycles after release edge
      idle(4);
      press();
      check("t1_busy_press", 32'(busy), 1);
      idle(6);
      release_key();
      t_ev = cyc;
      idle(14);
      check("t1_n_single", n_single, 1);
      check("t1_t_single", t_single, t_ev + 10);
      check("t1_other", n_double + n_long, 0);
      check("t1_busy_after", 32'(busy), 0);

      // 2) double press
      clear_stats();
      idle(2);
      press();
      idle(3);
      release_key();
      idle(4);
      press();
      idle(2);
      release_key();
      t_ev = cyc;
      idle(15);
      check("t2_n_double", n_double, 1);
      check("t2_t_double", t_double, t_ev);
      check("t2_n_single", n_single, 0);
      check("t2_n_long", n_long, 0);
      check("t2_busy_after", 32'(busy), 0);

      // 3) hold 40 cycles -> long at PRESS1 entry + 20, nothing on release
      clear_stats();
      idle(2);
      press();
      t_ev = cyc;
      idle(39);
      check("t3_busy_hold", 32'(busy), 1);
      release_key();
      idle(15);
      check("t3_n_long", n_long, 1);
      check("t3_t_long", t_long, t_ev + 20);
      check("t3_other", n_single + n_double, 0);
      check("t3_busy_after", 32'(busy), 0);

      // 4) release coincides with long timeout -> release wins, single follows
      clear_stats();
      idle(2);
      press();
      idle(19);
      release_key();
      t_ev = cyc;
      check("t4_busy_wait2", 32'(busy), 1);
      idle(14);
      check("t4_n_long", n_long, 0);
      check("t4_n_single", n_single, 1);
      check("t4_t_single", t_single, t_ev + 10);

      // 5) duplicate press in PRESS1 keeps timer running; release in IDLE ignored
      clear_stats();
      idle(2);
      press();
      t_ev = cyc;
      idle(3);
      press();
      idle(20);
      check("t5_n_long", n_long, 1);
      check("t5_t_long", t_long, t_ev + 20);
      release_key();
      idle(2);
      release_key();
      check("t5_busy_rel_idle", 32'(busy), 0);
      idle(15);
      check("t5_extra_pulses", n_single + n_double + n_long, 1);

      // 6) reset in WAIT2 at timer=8 discards the pending single press
      clear_stats();
      idle(2);
      press();
      idle(2);
      release_key();
      idle(8);
      sys_rst_n = 1'b0;
      idle(1);
      check("t6_busy_rst", 32'(busy), 0);
      check("t6_single_rst", 32'(single_press), 0);
      sys_rst_n = 1'b1;
      idle(15);
      check("t6_n_single", n_single, 0);
      check("t6_busy_after", 32'(busy), 0);

      check("one_hot_pulses", n_multi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule : tb_key_event_detector
